// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch path: field positions, widths,
// the jump opcode and the {pc, instruction} entry carried to decode.
package isa_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

  localparam logic [OPCODE_MSB-OPCODE_LSB:0] JUMP_OP = 6'b010100;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_entry_t;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input instr_t i);
    return i[OPCODE_MSB:OPCODE_LSB];
  endfunction

  // Jump target is the immediate field, zero-extended to a word address.
  function automatic addr_t imm_of(input instr_t i);
    return addr_t'(i[IMM_MSB:IMM_LSB]);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, instruction} entries with a
// registered head, occupancy count and a single-cycle flush.
module fetch_buffer
  import isa_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  fetch_entry_t           mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       rd_next;

  assign rd_next = rd_ptr + PTR_W'(1);

  // Storage, pointers, count and head register. The head is reloaded from
  // the entry behind it on a pop, or straight from the push data when the
  // incoming entry becomes the new head (empty, or last entry popping).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop && (count > CNT_W'(1))) begin
        head <= mem[rd_next];
      end else if (push && ((count == '0) || (pop && (count == CNT_W'(1))))) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, addresses instruction memory, follows
// unconditional jumps early, honours execute redirects, halts on a
// self-jump and queues {pc, instruction} pairs for decode.
module instruction_fetch_unit
  import isa_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned BUF_DEPTH   = 2,
  parameter logic [5:0]  JUMP_OPCODE = JUMP_OP,
  parameter bit          EARLY_JUMP  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [15:0] out_pc,
  output logic        halted
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  addr_t              fetch_pc;
  addr_t              next_pc;
  addr_t              target;
  logic               is_jump;
  logic               pop;
  logic               push;
  logic [CNT_W-1:0]   count;
  fetch_entry_t       head;
  fetch_entry_t       push_entry;

  assign imem_addr  = fetch_pc;
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign push       = !halted & !redirect_valid & ((count < CNT_W'(BUF_DEPTH)) | pop);
  assign target     = imm_of(imem_instr);
  assign is_jump    = EARLY_JUMP && (opcode_of(imem_instr) == JUMP_OPCODE);
  assign next_pc    = is_jump ? target : fetch_pc + 16'd1;
  assign push_entry = '{pc: fetch_pc, instr: imem_instr};
  assign out_pc     = head.pc;
  assign out_instr  = head.instr;

  // PC and halt flag: redirect wins, otherwise advance on every push; a
  // pushed jump to its own address stops fetching with the PC parked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      halted   <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      halted   <= 1'b0;
    end else if (push) begin
      fetch_pc <= next_pc;
      if (is_jump && (target == fetch_pc)) begin
        halted <= 1'b1;
      end
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: reset/stall vector table,
// directed jump/redirect/halt/wrap/reset sequences, then random traffic
// against a queue-based reference model.
module tb_instruction_fetch_unit;

  localparam logic [5:0] JOP = 6'b010100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr;
  logic [31:0] imem_instr;
  logic        rv = 1'b0;
  logic [15:0] rpc = 16'h0;
  logic        out_valid;
  logic        rdy = 1'b0;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;

  logic [31:0] mem [0:65535];
  assign imem_instr = mem[imem_addr];

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC    (16'h0000),
    .BUF_DEPTH   (2),
    .JUMP_OPCODE (6'b010100),
    .EARLY_JUMP  (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (rv),
    .redirect_pc    (rpc),
    .out_valid      (out_valid),
    .out_ready      (rdy),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of pending entries, fetch address, halt flag.
  typedef struct {
    logic [15:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        q[$];
  logic [15:0] mpc = 16'h0;
  bit          mh  = 1'b0;

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {6'b000001, 10'd0, a};
  endfunction

  function automatic logic [31:0] jmp(input logic [15:0] t);
    return {JOP, 10'd0, t};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mpc = 16'h0;
    mh  = 1'b0;
  endtask

  task automatic model_edge();
    bit          pop_m, push_m, j;
    logic [31:0] w;
    logic [15:0] tgt;
    pop_m  = (q.size() != 0) && rdy;
    push_m = !mh && !rv && ((q.size() < 2) || pop_m);
    if (rv) begin
      q.delete();
      mpc = rpc;
      mh  = 1'b0;
    end else begin
      if (pop_m) q.delete(0);
      if (push_m) begin
        w = mem[mpc];
        q.push_back('{mpc, w});
        j   = (w[31:26] == JOP);
        tgt = w[15:0];
        if (j && (tgt == mpc)) mh = 1'b1;
        mpc = j ? tgt : mpc + 16'd1;
      end
    end
  endtask

  task automatic compare_model();
    chk("valid", out_valid, q.size() != 0);
    chk("imem_addr", imem_addr, mpc);
    chk("halted", halted, mh);
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].instr);
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then
  // compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rv  = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          ev;
    logic [15:0] epc;
    logic [15:0] eaddr;
  } vec_t;

  vec_t        tbl [14];
  logic [15:0] seen[$];
  logic [15:0] exp_jump [8];
  int          n;

  initial begin
    tbl[0]  = '{1, 1, 0, 16'h0, 16'h0};
    tbl[1]  = '{0, 1, 1, 16'h0, 16'h1};
    tbl[2]  = '{0, 1, 1, 16'h1, 16'h2};
    tbl[3]  = '{0, 1, 1, 16'h2, 16'h3};
    tbl[4]  = '{0, 1, 1, 16'h3, 16'h4};
    tbl[5]  = '{1, 0, 0, 16'h0, 16'h0};
    tbl[6]  = '{0, 0, 1, 16'h0, 16'h1};
    tbl[7]  = '{0, 0, 1, 16'h0, 16'h2};
    tbl[8]  = '{0, 0, 1, 16'h0, 16'h2};
    tbl[9]  = '{0, 0, 1, 16'h0, 16'h2};
    tbl[10] = '{0, 0, 1, 16'h0, 16'h2};
    tbl[11] = '{0, 1, 1, 16'h1, 16'h3};
    tbl[12] = '{0, 1, 1, 16'h2, 16'h4};
    tbl[13] = '{0, 1, 1, 16'h3, 16'h5};
    exp_jump = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h10, 16'h11, 16'h12};

    for (int i = 0; i < 65536; i++) mem[i] = dflt(16'(i));

    // Asynchronous reset values before any clock edge.
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_addr", imem_addr, 16'h0);
    chk("rst_halted", halted, 0);

    // Vector table: streaming, then 5-cycle stall and release.
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst;
      rdy = tbl[i].rdy;
      step();
      chk("tbl_valid", out_valid, tbl[i].ev);
      chk("tbl_addr", imem_addr, tbl[i].eaddr);
      if (tbl[i].ev) begin
        chk("tbl_pc", out_pc, tbl[i].epc);
        chk("tbl_instr", out_instr, dflt(tbl[i].epc));
      end
    end

    // Early jump at address 4 to 0x10: address 5 never emitted.
    mem[4] = jmp(16'h0010);
    do_reset();
    rdy = 1'b1;
    seen.delete();
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) seen.push_back(out_pc);
    end
    chk("jump_len", seen.size() >= 8, 1);
    n = 0;
    foreach (seen[k]) if (seen[k] == 16'h5) n++;
    chk("jump_no5", n, 0);
    for (int i = 0; i < 8 && i < seen.size(); i++) chk("jump_seq", seen[i], exp_jump[i]);
    mem[4] = dflt(16'h4);

    // Redirect while the buffer is full.
    do_reset();
    rdy = 1'b0;
    repeat (3) step();
    chk("full_valid", out_valid, 1);
    rv  = 1'b1;
    rpc = 16'h0100;
    step();
    rv = 1'b0;
    chk("redir_gap", out_valid, 0);
    step();
    chk("redir_valid", out_valid, 1);
    chk("redir_pc", out_pc, 16'h0100);

    // Self-jump at 20 halts; redirect clears it.
    mem[20] = jmp(16'd20);
    rdy = 1'b1;
    rv  = 1'b1;
    rpc = 16'd20;
    step();
    rv = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid && out_pc == 16'd20) n++;
    end
    chk("halt_once", n, 1);
    chk("halt_flag", halted, 1);
    chk("halt_addr", imem_addr, 16'd20);
    rv  = 1'b1;
    rpc = 16'h0;
    step();
    rv = 1'b0;
    chk("halt_clear", halted, 0);
    mem[20] = dflt(16'd20);

    // PC wrap from 0xFFFF, then reset asserted mid-stall.
    rv  = 1'b1;
    rpc = 16'hFFFF;
    step();
    rv = 1'b0;
    step();
    chk("wrap_pc_ffff", out_pc, 16'hFFFF);
    step();
    chk("wrap_pc_0", out_pc, 16'h0000);
    rdy = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_addr", imem_addr, 16'h0);
    chk("midrst_pc", out_pc, 16'h0);
    step();
    rst = 1'b0;

    // Random traffic: jumps, self-jumps, stalls and redirects.
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 7))
        0: mem[i] = jmp(16'($urandom_range(0, 255)));
        1: mem[i] = jmp(16'(i));
        default: begin
          mem[i] = $urandom;
          if (mem[i][31:26] == JOP) mem[i][31:26] = 6'b000000;
        end
      endcase
    end
    for (int i = 0; i < 800; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = 16'($urandom_range(0, 255));
      step();
    end
    rv = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
